y86_seq_fde: RTL and testbench

//  Combined fetch/decode/execute front end of the Y86-64 single-cycle (SEQ) core.

---
 rtl/y86_seq_fde.sv | 200 ++++++++++++++++++++
 tb/tb_y86_seq_fde.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_seq_fde.sv
`default_nettype none
// ============================================================================
// Module  : y86_seq_fde
// Purpose : Y86-64 SEQ fetch/decode/execute front end. It splits the
//           instruction at pc, selects the register read sources, computes
//           valE/cnd and holds the condition codes.
// Rev     : 1.0  initial release
// ============================================================================
module y86_seq_fde #(
    parameter int IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pc,
    output logic [63:0] imem_addr,
    input  logic [79:0] imem_data,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    input  logic [63:0] rvalA,
    input  logic [63:0] rvalB,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [63:0] valE,
    output logic        cnd,
    output logic [2:0]  cc,
    output logic        halt,
    output logic        instr_inv,
    output logic        imem_error
);

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0]  REG_RSP    = 4'h4;
    localparam logic [3:0]  REG_NONE   = 4'hF;
    localparam logic [64:0] IMEM_LIMIT = 65'(IMEM_BYTES);

    logic        has_reg;
    logic        icode_ok;
    logic        ifun_ok;
    logic [3:0]  ilen;
    logic [64:0] fetch_end;
    logic        alu_of;
    logic        zf;
    logic        sf;
    logic        of;
    logic        cond_true;
    logic        cc_wr;
    logic [2:0]  cc_d;
    logic [2:0]  cc_q;

    // Fetch: field split, length, constant and the fetch-range check
    always_comb begin
        imem_addr = pc;
        icode     = imem_data[7:4];
        ifun      = imem_data[3:0];
        has_reg   = 1'b0;
        ilen      = 4'd1;
        valC      = 64'd0;
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                ilen    = 4'd2;
                has_reg = 1'b1;
            end
            I_JXX, I_CALL: begin
                ilen = 4'd9;
                valC = imem_data[71:8];
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                ilen    = 4'd10;
                has_reg = 1'b1;
                valC    = imem_data[79:16];
            end
            default: ilen = 4'd1;
        endcase
        rA = has_reg ? imem_data[15:12] : REG_NONE;
        rB = has_reg ? imem_data[11:8]  : REG_NONE;

        case (icode)
            I_OPQ:           ifun_ok = (ifun <= F_XOR);
            I_RRMOVQ, I_JXX: ifun_ok = (ifun <= C_G);
            default:         ifun_ok = (ifun == 4'h0);
        endcase
        icode_ok  = (icode <= I_POPQ);
        instr_inv = !(icode_ok && ifun_ok);

        // 65-bit sum so a pc near the top of the address space cannot wrap past the check
        fetch_end  = {1'b0, pc} + {61'd0, ilen};
        imem_error = (fetch_end > IMEM_LIMIT);
        valP       = (instr_inv || imem_error) ? pc : fetch_end[63:0];
        halt       = (icode == I_HALT);
    end

    // Decode: register-file read ports; REG_NONE reads as zero
    always_comb begin
        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: srcA = rA;
            I_RET, I_POPQ:                      srcA = REG_RSP;
            default:                            srcA = REG_NONE;
        endcase
        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:        srcB = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:   srcB = REG_RSP;
            default:                          srcB = REG_NONE;
        endcase
        valA = (srcA == REG_NONE) ? 64'd0 : rvalA;
        valB = (srcB == REG_NONE) ? 64'd0 : rvalB;
    end

    // Execute: ALU and its overflow flag
    always_comb begin
        valE   = 64'd0;
        alu_of = 1'b0;
        case (icode)
            I_RRMOVQ:           valE = valA;
            I_IRMOVQ:           valE = valC;
            I_RMMOVQ, I_MRMOVQ: valE = valB + valC;
            I_OPQ: begin
                case (ifun)
                    F_ADD: begin
                        valE   = valB + valA;
                        alu_of = (valA[63] == valB[63]) && (valE[63] != valA[63]);
                    end
                    F_SUB: begin
                        valE   = valB - valA;
                        alu_of = (valB[63] != valA[63]) && (valE[63] != valB[63]);
                    end
                    F_AND:   valE = valB & valA;
                    F_XOR:   valE = valB ^ valA;
                    default: valE = 64'd0;
                endcase
            end
            I_CALL, I_PUSHQ: valE = valB - 64'd8;
            I_RET, I_POPQ:   valE = valB + 64'd8;
            default:         valE = 64'd0;
        endcase
    end

    // Branch/move condition from the flags as they stand before this instruction
    always_comb begin
        {zf, sf, of} = cc_q;
        case (ifun)
            C_ALWAYS: cond_true = 1'b1;
            C_LE:     cond_true = (sf ^ of) | zf;
            C_L:      cond_true = sf ^ of;
            C_E:      cond_true = zf;
            C_NE:     cond_true = ~zf;
            C_GE:     cond_true = ~(sf ^ of);
            C_G:      cond_true = ~(sf ^ of) & ~zf;
            default:  cond_true = 1'b0;
        endcase
        cnd = ((icode == I_RRMOVQ) || (icode == I_JXX)) ? cond_true : 1'b0;
    end

    always_comb begin
        cc_wr = (icode == I_OPQ) && !instr_inv && !imem_error;
        cc_d  = cc_wr ? {(valE == 64'd0), valE[63], alu_of} : cc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= 3'b100;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cc = cc_q;

endmodule
`default_nettype wire

// File: tb/tb_y86_seq_fde.sv
`default_nettype none
// Testbench for y86_seq_fde: directed and random instructions scored against a
// behavioural Y86-64 front-end model through an expectation queue.
module tb_y86_seq_fde;

    localparam int IMEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pc = 64'd0;
    logic [63:0] imem_addr;
    logic [79:0] imem_data = 80'h10;
    logic [3:0]  icode, ifun, rA, rB, srcA, srcB;
    logic [63:0] valC, valP, valA, valB, valE;
    logic [63:0] rvalA = 64'd0;
    logic [63:0] rvalB = 64'd0;
    logic        cnd, halt, instr_inv, imem_error;
    logic [2:0]  cc;

    always #5 clk = ~clk;

    y86_seq_fde #(.IMEM_BYTES(IMEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .imem_addr(imem_addr),
        .imem_data(imem_data), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .srcA(srcA), .srcB(srcB),
        .rvalA(rvalA), .rvalB(rvalB), .valA(valA), .valB(valB), .valE(valE),
        .cnd(cnd), .cc(cc), .halt(halt), .instr_inv(instr_inv),
        .imem_error(imem_error)
    );

    typedef struct packed {
        logic [63:0] imem_addr, valC, valP, valA, valB, valE;
        logic [3:0]  icode, ifun, rA, rB, srcA, srcB;
        logic        cnd, halt, inv, merr, chk_alu;
        logic [2:0]  cc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [2:0] model_cc = 3'b100;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h (pc=%h data=%h)", nm, act, exp_v, pc, imem_data);
        end
    endtask

    function automatic logic [64:0] sext(input logic [63:0] v);
        return {v[63], v};
    endfunction

    // Reference model of one instruction; c is the flag state before it executes
    function automatic exp_t model(input logic [63:0] p, input logic [79:0] d,
                                   input logic [63:0] ra_v, input logic [63:0] rb_v,
                                   input logic [2:0] c, output logic [2:0] c_nxt);
        exp_t e;
        logic [7:0] b [10];
        int len;
        bit regbyte, legal, zf, sf, of, of_e, cond;
        logic signed [64:0] wide;
        logic [64:0] endaddr;
        for (int k = 0; k < 10; k++) b[k] = d[8*k +: 8];
        e = '0;
        e.imem_addr = p;
        e.icode = b[0][7:4];
        e.ifun  = b[0][3:0];
        case (e.icode)
            4'h0, 4'h1, 4'h9:       len = 1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 2;
            4'h7, 4'h8:             len = 9;
            4'h3, 4'h4, 4'h5:       len = 10;
            default:                len = 1;
        endcase
        regbyte = e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        e.rA = regbyte ? b[1][7:4] : 4'hF;
        e.rB = regbyte ? b[1][3:0] : 4'hF;
        if (e.icode inside {4'h7, 4'h8})
            for (int k = 0; k < 8; k++) e.valC[8*k +: 8] = b[1+k];
        else if (e.icode inside {4'h3, 4'h4, 4'h5})
            for (int k = 0; k < 8; k++) e.valC[8*k +: 8] = b[2+k];
        if (e.icode == 4'h6)                           legal = (e.ifun < 4);
        else if (e.icode == 4'h2 || e.icode == 4'h7)   legal = (e.ifun < 7);
        else                                           legal = (e.icode < 12) && (e.ifun == 0);
        e.inv   = !legal;
        endaddr = 65'(p) + 65'(len);
        e.merr  = (endaddr > 65'(IMEM_BYTES));
        e.valP  = (e.inv || e.merr) ? p : p + 64'(len);
        case (e.icode)
            4'h2, 4'h4, 4'h6, 4'hA: e.srcA = e.rA;
            4'h9, 4'hB:             e.srcA = 4'h4;
            default:                e.srcA = 4'hF;
        endcase
        case (e.icode)
            4'h4, 4'h5, 4'h6:       e.srcB = e.rB;
            4'h8, 4'h9, 4'hA, 4'hB: e.srcB = 4'h4;
            default:                e.srcB = 4'hF;
        endcase
        e.valA = (e.srcA == 4'hF) ? 64'd0 : ra_v;
        e.valB = (e.srcB == 4'hF) ? 64'd0 : rb_v;
        of_e = 1'b0;
        case (e.icode)
            4'h2:       e.valE = e.valA;
            4'h3:       e.valE = e.valC;
            4'h4, 4'h5: e.valE = e.valB + e.valC;
            4'h6: begin
                case (e.ifun)
                    4'h0: begin
                        wide = $signed(sext(e.valB)) + $signed(sext(e.valA));
                        e.valE = wide[63:0];
                        of_e = (wide[64] != wide[63]);
                    end
                    4'h1: begin
                        wide = $signed(sext(e.valB)) - $signed(sext(e.valA));
                        e.valE = wide[63:0];
                        of_e = (wide[64] != wide[63]);
                    end
                    4'h2:    e.valE = e.valB & e.valA;
                    4'h3:    e.valE = e.valB ^ e.valA;
                    default: e.valE = 64'd0;
                endcase
            end
            4'h8, 4'hA: e.valE = e.valB - 64'd8;
            4'h9, 4'hB: e.valE = e.valB + 64'd8;
            default:    e.valE = 64'd0;
        endcase
        e.chk_alu = !e.inv;
        {zf, sf, of} = c;
        case (e.ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = (sf != of) || zf;
            4'h2:    cond = (sf != of);
            4'h3:    cond = zf;
            4'h4:    cond = !zf;
            4'h5:    cond = (sf == of);
            4'h6:    cond = (sf == of) && !zf;
            default: cond = 1'b0;
        endcase
        e.cnd  = (e.icode == 4'h2 || e.icode == 4'h7) && cond;
        e.cc   = c;
        e.halt = (e.icode == 4'h0);
        c_nxt  = (e.icode == 4'h6 && legal && !e.merr) ? {e.valE == 64'd0, e.valE[63], of_e} : c;
        return e;
    endfunction

    task automatic issue(input logic [63:0] p, input logic [79:0] d,
                         input logic [63:0] ra_v, input logic [63:0] rb_v, input bit hold_rst);
        exp_t e;
        logic [2:0] nxt;
        @(posedge clk);
        #1;
        rst_n = hold_rst ? 1'b0 : 1'b1;
        pc = p; imem_data = d; rvalA = ra_v; rvalB = rb_v;
        if (hold_rst) model_cc = 3'b100;
        e = model(p, d, ra_v, rb_v, model_cc, nxt);
        exp_q.push_back(e);
        model_cc = hold_rst ? 3'b100 : nxt;
    endtask

    // Monitor: the design is combinational, so outputs are valid mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("imem_addr",  imem_addr,  e.imem_addr);
            chk("icode",      64'(icode), 64'(e.icode));
            chk("ifun",       64'(ifun),  64'(e.ifun));
            chk("rA",         64'(rA),    64'(e.rA));
            chk("rB",         64'(rB),    64'(e.rB));
            chk("valC",       valC,       e.valC);
            chk("valP",       valP,       e.valP);
            chk("srcA",       64'(srcA),  64'(e.srcA));
            chk("srcB",       64'(srcB),  64'(e.srcB));
            chk("valA",       valA,       e.valA);
            chk("valB",       valB,       e.valB);
            if (e.chk_alu) chk("valE", valE, e.valE);
            chk("cnd",        64'(cnd),        64'(e.cnd));
            chk("cc",         64'(cc),         64'(e.cc));
            chk("halt",       64'(halt),       64'(e.halt));
            chk("instr_inv",  64'(instr_inv),  64'(e.inv));
            chk("imem_error", 64'(imem_error), 64'(e.merr));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // directed cases
        issue(64'd0, 80'h10, 64'd0, 64'd0, 1'b1);
        issue(64'd0, 80'h10, 64'd0, 64'd0, 1'b0);
        issue(64'd0, 80'h0000_0000_0000_0010_F030, 64'd0, 64'd0, 1'b0);
        issue(64'h40, 80'h0360, 64'd5, 64'd7, 1'b0);
        issue(64'h42, 80'h0361, 64'd9, 64'd9, 1'b0);
        issue(64'h44, 80'h0000_0000_0000_0000_0074, 64'd0, 64'd0, 1'b0);
        issue(64'h4D, 80'h0000_0000_0000_0000_0073, 64'd0, 64'd0, 1'b0);
        issue(64'h56, 80'h0360, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
        issue(64'h58, 80'h10, 64'd0, 64'd0, 1'b0);
        issue(64'h20, 80'h0FA0, 64'd0, 64'h100, 1'b0);
        issue(64'h22, 80'hC0, 64'd0, 64'd0, 1'b0);
        issue(64'(IMEM_BYTES - 2), 80'h0000_0000_0000_0010_F030, 64'd0, 64'd0, 1'b0);
        issue(64'h30, 80'h0361, 64'd3, 64'd1, 1'b0);
        issue(64'h32, 80'h0360, 64'd1, 64'd1, 1'b1);
        issue(64'h34, 80'h10, 64'd0, 64'd0, 1'b0);

        // random instructions
        for (int n = 0; n < 400; n++) begin
            logic [3:0]  ic, fn;
            logic [79:0] d;
            logic [63:0] p, a, b;
            bit          r;
            ic = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
            if ($urandom_range(0, 7) == 0)      fn = 4'($urandom);
            else if (ic == 4'h6)                fn = 4'($urandom_range(0, 3));
            else if (ic == 4'h2 || ic == 4'h7)  fn = 4'($urandom_range(0, 6));
            else                                fn = 4'h0;
            d = {16'($urandom), $urandom, $urandom};
            d[7:0] = {ic, fn};
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: b = a;
                1: begin a = 64'd1; b = 64'h7FFF_FFFF_FFFF_FFFF; end
                2: b = 64'h8000_0000_0000_0000;
                3: a = 64'h8000_0000_0000_0000;
                default: ;
            endcase
            p = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(IMEM_BYTES - 12, IMEM_BYTES + 4))
                                            : 64'($urandom_range(0, IMEM_BYTES - 12));
            r = ($urandom_range(0, 39) == 0);
            issue(p, d, a, b, r);
        end

        repeat (2) @(posedge clk);
        chk("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
